// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB encodings and state type for the SRAM responder.
// Also holds the byte-lane decode used by the write port.
package ahb_sram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } ahb_slv_state_t;

    // Little-endian lane select; illegal sizes never reach the array.
    function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lane;
            HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Register-array storage: byte-enable synchronous write, asynchronous read.
// Contents are deliberately not reset.
module ahb_sram_array #(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          hclk,
    input  logic          wr_en,
    input  logic [3:0]    wr_be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge hclk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with programmable wait states and two-cycle ERROR.
// Address phase is validated at accept; only clean writes reach the array.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic        hready_out,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    ahb_slv_state_t state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW+1:0]  addr_q, addr_d;
    logic           write_q, write_d;
    logic [2:0]     size_q, size_d;

    logic [31:0] offset;
    logic        accept;
    logic        addr_err;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign unused_bits = ^{hburst, htrans[0]};

    // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
    assign offset   = haddr - BASE_ADDR;
    assign accept   = hsel & htrans[1] & hready_in;
    assign addr_err = (offset[31:AW+2] != '0)
                    | (hsize > HSIZE_WORD)
                    | ((hsize == HSIZE_HALF) && haddr[0])
                    | ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));

    always_ff @(posedge hclk or negedge hreset) begin
        if (!hreset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE, DATA and ERR2 can all take a new address phase.
                state_d = S_IDLE;
                if (accept) begin
                    addr_d  = offset[AW+1:0];
                    write_d = hwrite;
                    size_d  = hsize;
                    if (addr_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    always_comb begin
        hready_out = 1'b1;
        hresp      = HRESP_OKAY;
        hrdata     = '0;
        wr_en      = 1'b0;
        case (state_q)
            S_WAIT: hready_out = 1'b0;
            S_DATA: begin
                if (write_q) begin
                    wr_en = 1'b1;
                end else begin
                    hrdata = rd_data;
                end
            end
            S_ERR1: begin
                hready_out = 1'b0;
                hresp      = HRESP_ERROR;
            end
            S_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    assign wr_be = byte_enables(size_q, addr_q[1:0]);

    ahb_sram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .hclk    (hclk),
        .wr_en   (wr_en),
        .wr_be   (wr_be),
        .addr    (addr_q[AW+1:2]),
        .wr_data (hwdata),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench: a zero-wait slave and a two-wait-state slave share one bus;
// stimulus queues expected responses, the monitor checks each data phase.
module tb_ahb_sram_slave;

    localparam logic [31:0] B_BASE = 32'h1000_0000;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel_a, hsel_b;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        force_nrdy;
    logic        hready_in;
    logic        hready_out_a, hready_out_b;
    logic [1:0]  hresp_a, hresp_b;
    logic [31:0] hrdata_a, hrdata_b;

    typedef struct {
        int          dut;
        int          waits;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] wdata_pend = '0;
    bit          pend[2];
    int          waits[2];

    always #5 hclk = ~hclk;

    assign hready_in = !force_nrdy & hready_out_a & hready_out_b;

    ahb_sram_slave #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut_a (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hready_in(hready_in), .hready_out(hready_out_a), .hresp(hresp_a), .hrdata(hrdata_a)
    );

    ahb_sram_slave #(.DEPTH_WORDS(16), .BASE_ADDR(B_BASE), .WAIT_STATES(2)) dut_b (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hready_in(hready_in), .hready_out(hready_out_b), .hresp(hresp_b), .hrdata(hrdata_b)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge hclk);
        while (!hready_in && n < 64) begin
            @(negedge hclk);
            n++;
        end
        if (n >= 64) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL hready_timeout: got hready_in=0, expected 1 within 64 cycles");
        end
    endtask

    task automatic apply_stimulus(input int dut, input logic [31:0] addr, input logic wr,
                                  input logic [2:0] size, input logic [31:0] wdata,
                                  input int exp_waits, input logic [1:0] exp_resp,
                                  input logic [31:0] exp_rdata);
        exp_t e;
        hsel_a = (dut == 0);
        hsel_b = (dut == 1);
        haddr  = addr;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = size;
        hwdata = wdata_pend;
        e.dut = dut; e.waits = exp_waits; e.resp = exp_resp; e.rdata = exp_rdata;
        exp_q.push_back(e);
        wait_ready();
        @(posedge hclk); #1;
        wdata_pend = wdata;
    endtask

    task automatic go_idle(input int cycles);
        hsel_a = 1'b0;
        hsel_b = 1'b0;
        htrans = 2'b00;
        hwdata = wdata_pend;
        for (int i = 0; i < cycles; i++) begin
            wait_ready();
            @(posedge hclk); #1;
        end
    endtask

    // Monitor: idle cycles must be zero-wait OKAY; a data phase is checked when it completes.
    initial begin
        logic        rdy;
        logic [1:0]  rsp;
        logic [31:0] rd;
        logic        sel;
        exp_t        e;
        forever begin
            @(negedge hclk);
            for (int d = 0; d < 2; d++) begin
                rdy = (d == 0) ? hready_out_a : hready_out_b;
                rsp = (d == 0) ? hresp_a : hresp_b;
                rd  = (d == 0) ? hrdata_a : hrdata_b;
                sel = (d == 0) ? hsel_a : hsel_b;
                if (!hreset || !pend[d]) begin
                    pend[d]  = 1'b0;
                    waits[d] = 0;
                    check_output($sformatf("idle_ready_%0d", d), 32'(rdy), 32'd1);
                    check_output($sformatf("idle_resp_%0d", d), 32'(rsp), 32'd0);
                    check_output($sformatf("idle_rdata_%0d", d), rd, 32'd0);
                end else if (!rdy) begin
                    waits[d]++;
                end else begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_response_%0d: got completion, expected none", d);
                    end else begin
                        e = exp_q.pop_front();
                        check_output($sformatf("dut_id_%0d", d), 32'(d), 32'(e.dut));
                        check_output($sformatf("wait_cycles_%0d", d), 32'(waits[d]), 32'(e.waits));
                        check_output($sformatf("hresp_%0d", d), 32'(rsp), 32'(e.resp));
                        check_output($sformatf("hrdata_%0d", d), rd, e.rdata);
                    end
                    pend[d]  = 1'b0;
                    waits[d] = 0;
                end
                if (hreset && sel && htrans[1] && hready_in) pend[d] = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected end before 1000000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        hreset = 1'b0; hsel_a = 1'b0; hsel_b = 1'b0; haddr = '0; htrans = 2'b00;
        hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0; hwdata = '0; force_nrdy = 1'b0;
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b1;
        go_idle(1);

        // zero-wait pipelined write then read
        apply_stimulus(0, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, 0, 2'b00, 32'h0);
        apply_stimulus(0, 32'h10, 1'b0, 3'd2, 32'h0, 0, 2'b00, 32'hDEAD_BEEF);
        go_idle(2);

        // byte lanes
        apply_stimulus(0, 32'h20, 1'b1, 3'd2, 32'h1122_3344, 0, 2'b00, 32'h0);
        apply_stimulus(0, 32'h21, 1'b1, 3'd0, 32'h0000_AA00, 0, 2'b00, 32'h0);
        apply_stimulus(0, 32'h22, 1'b1, 3'd1, 32'h5566_0000, 0, 2'b00, 32'h0);
        apply_stimulus(0, 32'h20, 1'b0, 3'd2, 32'h0, 0, 2'b00, 32'h5566_AA44);
        go_idle(2);

        // errors: range, misaligned half write, illegal size, misaligned word
        apply_stimulus(0, 32'h400, 1'b0, 3'd2, 32'h0, 1, 2'b01, 32'h0);
        apply_stimulus(0, 32'h30, 1'b1, 3'd2, 32'hCAFE_F00D, 0, 2'b00, 32'h0);
        apply_stimulus(0, 32'h31, 1'b1, 3'd1, 32'hFFFF_FFFF, 1, 2'b01, 32'h0);
        apply_stimulus(0, 32'h30, 1'b0, 3'd2, 32'h0, 0, 2'b00, 32'hCAFE_F00D);
        apply_stimulus(0, 32'h30, 1'b0, 3'd3, 32'h0, 1, 2'b01, 32'h0);
        apply_stimulus(0, 32'h32, 1'b1, 3'd2, 32'h0BAD_0BAD, 1, 2'b01, 32'h0);
        go_idle(2);

        // non-accept: BUSY, then NONSEQ while hready_in is held low
        hsel_a = 1'b1; haddr = 32'h30; htrans = 2'b01; hwrite = 1'b1; hsize = 3'd2;
        hwdata = 32'hBAD0_BAD0;
        repeat (2) begin @(posedge hclk); #1; end
        htrans = 2'b10; force_nrdy = 1'b1;
        repeat (2) begin @(posedge hclk); #1; end
        force_nrdy = 1'b0; hsel_a = 1'b0; htrans = 2'b00;
        go_idle(1);
        apply_stimulus(0, 32'h30, 1'b0, 3'd2, 32'h0, 0, 2'b00, 32'hCAFE_F00D);
        go_idle(1);

        // two wait states on slave B
        apply_stimulus(1, B_BASE + 32'h8, 1'b1, 3'd2, 32'h1234_5678, 2, 2'b00, 32'h0);
        apply_stimulus(1, B_BASE + 32'h8, 1'b0, 3'd2, 32'h0, 2, 2'b00, 32'h1234_5678);
        apply_stimulus(1, B_BASE - 32'h4, 1'b0, 3'd2, 32'h0, 1, 2'b01, 32'h0);
        apply_stimulus(1, B_BASE + 32'h40, 1'b0, 3'd2, 32'h0, 1, 2'b01, 32'h0);
        go_idle(2);

        // reset during WAIT of a write drops the write
        apply_stimulus(1, B_BASE + 32'hC, 1'b1, 3'd2, 32'h1111_1111, 2, 2'b00, 32'h0);
        apply_stimulus(1, B_BASE + 32'hC, 1'b1, 3'd2, 32'h9999_9999, 2, 2'b00, 32'h0);
        hsel_b = 1'b0; htrans = 2'b00; hwdata = wdata_pend;
        @(posedge hclk); #1;
        hreset = 1'b0;
        exp_q.delete();
        wdata_pend = '0;
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b1;
        go_idle(1);
        apply_stimulus(1, B_BASE + 32'hC, 1'b0, 3'd2, 32'h0, 2, 2'b00, 32'h1111_1111);
        go_idle(3);

        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
